counter_bank_reader: RTL and testbench

- Read-side companion to the team's parametric counter banks, including the N-instance generated 8-bit counter array.
- On request, atomically snapshots a packed N x WIDTH counter vector into a shadow register.
- Streams the snapshot out one WIDTH-bit word per transfer over a valid/ready handshake, with an index tag per word.
- Sits between the counter bank and a downstream consumer (UART framer, debug bus); decouples sampling time from readout time.

---
 rtl/counter_bank_reader_if.sv | 30 +++
 rtl/counter_bank_reader.sv | 132 +++++++++++++
 tb/tb_counter_bank_reader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/counter_bank_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_bank_reader_if : snapshot request + streamed word handshake      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface counter_bank_reader_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic [N*WIDTH-1:0] cnt_in;
  logic               snap_req;
  logic               busy;
  logic [WIDTH-1:0]   dout;
  logic [IDX_W-1:0]   dout_idx;
  logic               dout_valid;
  logic               dout_ready;
  logic               done;

  modport master (
    input  cnt_in, snap_req, dout_ready,
    output busy, dout, dout_idx, dout_valid, done
  );

  modport slave (
    output cnt_in, snap_req, dout_ready,
    input  busy, dout, dout_idx, dout_valid, done
  );
endinterface
`default_nettype wire

// File: rtl/counter_bank_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_bank_reader : snapshots a packed counter vector and streams it    |
// | word by word; READER_CHECKSUM_EN appends an XOR checksum word.  Rev 1.0   |
// +--------------------------------------------------------------------------+
module counter_bank_reader #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  counter_bank_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
`ifdef READER_CHECKSUM_EN
    , CHK = 2'd2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [N*WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   next_idx;
  logic [WIDTH-1:0]   next_word;
  logic               last_word;
  logic               accept;

  // Word lookup by compare-and-select keeps widths exact for any N.
  always_comb begin
    next_idx  = idx_q + 1'b1;
    next_word = '0;
    for (int i = 0; i < N; i++) begin
      if (next_idx == IDX_W'(i)) next_word = shadow_q[i*WIDTH +: WIDTH];
    end
  end

`ifdef READER_CHECKSUM_EN
  logic [WIDTH-1:0] chk_word;
  always_comb begin
    chk_word = '0;
    for (int i = 0; i < N; i++) chk_word = chk_word ^ shadow_q[i*WIDTH +: WIDTH];
  end
`endif

  assign last_word = (idx_q == IDX_W'(N-1));
  assign accept    = valid_q && bus.dout_ready;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.snap_req) begin
          shadow_d = bus.cnt_in;
          dout_d   = bus.cnt_in[WIDTH-1:0];
          idx_d    = '0;
          valid_d  = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (!last_word) begin
            idx_d  = next_idx;
            dout_d = next_word;
          end else begin
`ifdef READER_CHECKSUM_EN
            idx_d   = IDX_W'(N);
            dout_d  = chk_word;
            state_d = CHK;
`else
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef READER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      dout_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.dout       = dout_q;
  assign bus.dout_idx   = idx_q;
  assign bus.dout_valid = valid_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_bank_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_counter_bank_reader : directed + random stimulus vs. a word-queue model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_counter_bank_reader;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   tests   = 0;
  int   fails   = 0;
  int   done_seen = 0;

  // Reference: words still owed to the consumer, in delivery order.
  logic [WIDTH-1:0] exp_w[$];
  logic [IDX_W-1:0] exp_i[$];
  logic             exp_done = 1'b0;

  counter_bank_reader_if #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  counter_bank_reader #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_model(input logic [31:0] cin);
    logic [WIDTH-1:0] x;
    x = '0;
    for (int i = 0; i < N; i++) begin
      exp_w.push_back(cin[8*i +: 8]);
      exp_i.push_back(IDX_W'(i));
      x = x ^ cin[8*i +: 8];
    end
`ifdef READER_CHECKSUM_EN
    exp_w.push_back(x);
    exp_i.push_back(IDX_W'(N));
`endif
  endtask

  task automatic compare_outputs();
    if (bus.done === 1'b1) done_seen++;
    check("busy",  32'(bus.busy),       32'(exp_w.size() != 0));
    check("valid", 32'(bus.dout_valid), 32'(exp_w.size() != 0));
    check("done",  32'(bus.done),       32'(exp_done));
    if (exp_w.size() != 0) begin
      check("dout", 32'(bus.dout),     32'(exp_w[0]));
      check("idx",  32'(bus.dout_idx), 32'(exp_i[0]));
    end
  endtask

  // Drive inputs after a falling edge, advance the model at the rising edge,
  // compare at the next falling edge.
  task automatic cycle(input logic sr, input logic rdy, input logic [31:0] cin);
    bus.snap_req   = sr;
    bus.dout_ready = rdy;
    bus.cnt_in     = cin;
    @(posedge clk);
    exp_done = 1'b0;
    if (exp_w.size() != 0) begin
      if (rdy) begin
        void'(exp_w.pop_front());
        void'(exp_i.pop_front());
        if (exp_w.size() == 0) exp_done = 1'b1;
      end
    end else if (sr) begin
      load_model(cin);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_dout"},  32'(bus.dout),       32'h0);
    check({tag, "_idx"},   32'(bus.dout_idx),   32'h0);
    check({tag, "_valid"}, 32'(bus.dout_valid), 32'h0);
    check({tag, "_busy"},  32'(bus.busy),       32'h0);
    check({tag, "_done"},  32'(bus.done),       32'h0);
  endtask

  localparam logic [31:0] C_A = 32'h44332211;
  localparam logic [31:0] C_B = 32'hDDCCBBAA;

  initial begin
    int d0;
    bus.snap_req   = 1'b0;
    bus.dout_ready = 1'b0;
    bus.cnt_in     = '0;
    #1 reset_n = 1'b0;
    #1 check_reset_zero("rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Basic stream
    cycle(1'b1, 1'b1, C_A); check("basic_w0", 32'(bus.dout), 32'h11);
    cycle(1'b0, 1'b1, C_A); check("basic_w1", 32'(bus.dout), 32'h22);
    cycle(1'b0, 1'b1, C_A); check("basic_w2", 32'(bus.dout), 32'h33);
    cycle(1'b0, 1'b1, C_A); check("basic_w3", 32'(bus.dout), 32'h44);
`ifdef READER_CHECKSUM_EN
    cycle(1'b0, 1'b1, C_A);
    check("chk_word", 32'(bus.dout), 32'h44);
    check("chk_idx",  32'(bus.dout_idx), 32'h4);
`endif
    cycle(1'b0, 1'b1, C_A);
    check("basic_done", 32'(bus.done), 32'h1);
    check("basic_busy", 32'(bus.busy), 32'h0);
    cycle(1'b0, 1'b1, C_A);

    // Backpressure at idx 1
    cycle(1'b1, 1'b1, C_A);
    cycle(1'b0, 1'b1, C_A);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, C_A);
      check("bp_hold_dout", 32'(bus.dout), 32'h22);
      check("bp_hold_idx",  32'(bus.dout_idx), 32'h1);
    end
    cycle(1'b0, 1'b1, C_A); check("bp_resume", 32'(bus.dout), 32'h33);
    repeat (N + 2) cycle(1'b0, 1'b1, C_A);

    // Snapshot isolation: new cnt_in and snap_req while busy
    d0 = done_seen;
    cycle(1'b1, 1'b1, C_A);
`ifdef READER_CHECKSUM_EN
    repeat (N + 1) cycle(1'b1, 1'b1, C_B);
`else
    repeat (N) cycle(1'b1, 1'b1, C_B);
`endif
    repeat (3) cycle(1'b0, 1'b1, C_B);
    check("iso_one_done", 32'(done_seen - d0), 32'h1);

    // Reset mid-transfer at idx 2
    cycle(1'b1, 1'b1, C_A);
    cycle(1'b0, 1'b1, C_A);
    cycle(1'b0, 1'b1, C_A);
    check("mid_idx2", 32'(bus.dout_idx), 32'h2);
    bus.snap_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_zero("midrst");
    exp_w.delete(); exp_i.delete(); exp_done = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_no_done", 32'(bus.done), 32'h0);
    reset_n = 1'b1;
    cycle(1'b1, 1'b1, C_B);
    check("post_rst_w0", 32'(bus.dout), 32'hAA);
    check("post_rst_idx", 32'(bus.dout_idx), 32'h0);
    repeat (N + 2) cycle(1'b0, 1'b1, C_B);

    // Back-to-back with snap_req held high
    repeat (30) cycle(1'b1, 1'b1, $urandom);
    repeat (N + 2) cycle(1'b0, 1'b1, 32'h0);

    // Random traffic
    for (int k = 0; k < 3000; k++)
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), $urandom);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
